// File: rtl/chain_pkg.sv
// Shared chaining types and defaults, used by the DP engine and by chain_backtrack.
// Also holds the backtracker FSM state encoding.
package chain_pkg;

  localparam int MAX_ANCHORS_DEF = 4096;
  localparam int SCORE_W_DEF     = 32;
  localparam int IDX_W_DEF       = $clog2(MAX_ANCHORS_DEF) + 1;

  typedef logic signed [SCORE_W_DEF-1:0] score_t;
  typedef logic signed [IDX_W_DEF-1:0]   idx_t;

  // Predecessor value meaning "chain starts here".
  localparam idx_t NO_PRED = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_TRACE,
    ST_DONE
  } bt_state_e;

endpackage

// File: rtl/chain_bt_mem.sv
// f/p register file (one write port, two combinational read ports) plus the
// per-anchor visited vector with single-bit set and bulk clear.
module chain_bt_mem #(
  parameter int DEPTH   = 4096,
  parameter int AW      = 12,
  parameter int SCORE_W = 32,
  parameter int IDX_W   = 13
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we_i,
  input  logic [AW-1:0]             waddr_i,
  input  logic signed [SCORE_W-1:0] wf_i,
  input  logic signed [IDX_W-1:0]   wp_i,
  input  logic [AW-1:0]             ra_addr_i,
  output logic signed [SCORE_W-1:0] ra_f_o,
  output logic signed [IDX_W-1:0]   ra_p_o,
  output logic                      ra_vis_o,
  input  logic [AW-1:0]             rb_addr_i,
  output logic signed [SCORE_W-1:0] rb_f_o,
  output logic                      rb_vis_o,
  input  logic                      vis_set_i,
  input  logic [AW-1:0]             vis_set_addr_i,
  input  logic                      vis_clr_i
);

  logic signed [SCORE_W-1:0] f_mem [DEPTH];
  logic signed [IDX_W-1:0]   p_mem [DEPTH];
  logic [DEPTH-1:0]          vis_q;

  // NOTE: the register file is deliberately not reset: every entry read is
  // written during LOAD first, and resetting DEPTH words would cost a wide reset tree.
  always_ff @(posedge clk) begin
    if (we_i) begin
      f_mem[waddr_i] <= wf_i;
      p_mem[waddr_i] <= wp_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_q <= '0;
    end else if (vis_clr_i) begin
      vis_q <= '0;
    end else if (vis_set_i) begin
      vis_q[vis_set_addr_i] <= 1'b1;
    end
  end

  assign ra_f_o   = f_mem[ra_addr_i];
  assign ra_p_o   = p_mem[ra_addr_i];
  assign ra_vis_o = vis_q[ra_addr_i];
  assign rb_f_o   = f_mem[rb_addr_i];
  assign rb_vis_o = vis_q[rb_addr_i];

endmodule

// File: rtl/chain_backtrack.sv
// Buffers the DP f/p stream, then backtracks predecessor links and emits chains
// highest index first. Optional CHAIN_BT_STATS_EN adds chain/kept counters.
module chain_backtrack
  import chain_pkg::*;
#(
  parameter int MAX_ANCHORS = MAX_ANCHORS_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int IDX_W       = $clog2(MAX_ANCHORS) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [SCORE_W-1:0] min_sc,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [SCORE_W-1:0] in_f,
  input  logic signed [IDX_W-1:0]   in_p,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  output logic signed [SCORE_W-1:0] out_score,
  output logic                      out_keep,
  output logic                      busy,
  output logic                      done,
`ifdef CHAIN_BT_STATS_EN
  output logic [IDX_W-1:0]          stat_chains,
  output logic [IDX_W-1:0]          stat_kept,
`endif
  output logic                      overflow
);

  localparam int AW = IDX_W - 1;
  localparam logic [IDX_W-1:0]          MAX_N = IDX_W'(MAX_ANCHORS);
  localparam logic signed [IDX_W-1:0]   NO_Q  = IDX_W'(NO_PRED);
  localparam logic signed [SCORE_W-1:0] S_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic signed [SCORE_W-1:0] S_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  bt_state_e                 state_q, state_d;
  logic signed [SCORE_W-1:0] min_sc_q, min_sc_d, s_q, s_d;
  logic [IDX_W-1:0]          n_q, n_d, i_q, i_d, j_q, j_d;
  logic                      overflow_q, overflow_d;

  logic signed [SCORE_W-1:0] ra_f, rb_f, sub_f, score_w;
  logic signed [IDX_W-1:0]   ra_p, q_eff;
  logic                      ra_vis, rb_vis;
  logic [IDX_W-1:0]          q_u;
  logic                      q_valid, last_w, keep_w;
  logic                      trace, start_go, load_hs, store, out_hs;
  logic signed [SCORE_W:0]   diff;

  assign trace    = (state_q == ST_TRACE);
  assign start_go = (state_q == ST_IDLE) && start;
  assign load_hs  = (state_q == ST_LOAD) && in_valid;
  assign store    = load_hs && (n_q < MAX_N);
  assign out_hs   = trace && out_ready;

  chain_bt_mem #(
    .DEPTH  (MAX_ANCHORS),
    .AW     (AW),
    .SCORE_W(SCORE_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk           (clk),
    .rst_n         (rst),
    .we_i          (store),
    .waddr_i       (n_q[AW-1:0]),
    .wf_i          (in_f),
    .wp_i          (in_p),
    .ra_addr_i     ((state_q == ST_SCAN) ? i_q[AW-1:0] : j_q[AW-1:0]),
    .ra_f_o        (ra_f),
    .ra_p_o        (ra_p),
    .ra_vis_o      (ra_vis),
    .rb_addr_i     (q_valid ? q_u[AW-1:0] : '0),
    .rb_f_o        (rb_f),
    .rb_vis_o      (rb_vis),
    .vis_set_i     (out_hs),
    .vis_set_addr_i(j_q[AW-1:0]),
    .vis_clr_i     (start_go)
  );

  // Out-of-range or forward-pointing predecessors end the chain.
  assign q_u     = ra_p;
  assign q_valid = !ra_p[IDX_W-1] && (q_u < j_q) && (q_u < n_q);
  assign q_eff   = q_valid ? ra_p : NO_Q;
  assign last_w  = (q_eff == NO_Q) || rb_vis;
  assign sub_f   = q_valid ? rb_f : '0;
  assign diff    = {s_q[SCORE_W-1], s_q} - {sub_f[SCORE_W-1], sub_f};

  always_comb begin
    if (diff[SCORE_W] != diff[SCORE_W-1]) score_w = diff[SCORE_W] ? S_MIN : S_MAX;
    else                                  score_w = diff[SCORE_W-1:0];
  end

  assign keep_w = (score_w >= min_sc_q);

  // NOTE: state and datapath registers use non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      min_sc_q   <= '0;
      s_q        <= '0;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_sc_q   <= min_sc_d;
      s_q        <= s_d;
      n_q        <= n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: every variable gets a hold default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    min_sc_d   = min_sc_q;
    s_d        = s_q;
    n_d        = n_q;
    i_d        = i_q;
    j_d        = j_q;
    overflow_d = overflow_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_LOAD;
        min_sc_d   = min_sc;
        n_d        = '0;
        overflow_d = 1'b0;
      end
      ST_LOAD: if (load_hs) begin
        if (store) n_d = n_q + IDX_W'(1);
        else       overflow_d = 1'b1;
        if (in_last) begin
          state_d = ST_SCAN;
          i_d     = n_d - IDX_W'(1);
        end
      end
      ST_SCAN: begin
        if (!ra_vis && (ra_f >= min_sc_q)) begin
          state_d = ST_TRACE;
          j_d     = i_q;
          s_d     = ra_f;
        end else if (i_q == '0) begin
          state_d = ST_DONE;
        end else begin
          i_d = i_q - IDX_W'(1);
        end
      end
      ST_TRACE: if (out_ready) begin
        if (!last_w) begin
          j_d = q_u;
        end else if (i_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SCAN;
          i_d     = i_q - IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    out_valid = trace;
    out_idx   = trace ? j_q : '0;
    out_last  = trace && last_w;
    out_score = trace ? score_w : '0;
    out_keep  = trace && keep_w;
  end

  assign overflow = overflow_q;

`ifdef CHAIN_BT_STATS_EN
  logic [IDX_W-1:0] chains_q, kept_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chains_q <= '0;
      kept_q   <= '0;
    end else if (start_go) begin
      chains_q <= '0;
      kept_q   <= '0;
    end else if (out_hs && last_w) begin
      chains_q <= chains_q + IDX_W'(1);
      if (keep_w) kept_q <= kept_q + IDX_W'(1);
    end
  end

  assign stat_chains = chains_q;
  assign stat_kept   = kept_q;
`endif

endmodule

// File: tb/tb_chain_backtrack.sv
// Self-checking bench for chain_backtrack: directed and randomized reads checked
// against a behavioural chain model; a 4-anchor instance covers overflow.
module tb_chain_backtrack;

  localparam int CAP_A = 32;
  localparam int CAP_B = 4;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_last, out_ready, sel;
  logic signed [31:0] min_sc, in_f;
  logic signed [5:0]  in_p;

  logic a_in_ready, a_out_valid, a_out_last, a_out_keep, a_busy, a_done, a_overflow;
  logic [5:0] a_out_idx;
  logic signed [31:0] a_out_score;
  logic b_in_ready, b_out_valid, b_out_last, b_out_keep, b_busy, b_done, b_overflow;
  logic [2:0] b_out_idx;
  logic signed [31:0] b_out_score;
`ifdef CHAIN_BT_STATS_EN
  logic [5:0] a_stat_chains, a_stat_kept;
  logic [2:0] b_stat_chains, b_stat_kept;
`endif

  always #5 clk = ~clk;

  chain_backtrack #(.MAX_ANCHORS(CAP_A), .SCORE_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start && !sel), .min_sc(min_sc),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_f(in_f), .in_p(in_p), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_idx(a_out_idx), .out_last(a_out_last),
    .out_score(a_out_score), .out_keep(a_out_keep), .busy(a_busy), .done(a_done),
`ifdef CHAIN_BT_STATS_EN
    .stat_chains(a_stat_chains), .stat_kept(a_stat_kept),
`endif
    .overflow(a_overflow)
  );

  chain_backtrack #(.MAX_ANCHORS(CAP_B), .SCORE_W(32)) dut_b (
    .clk(clk), .rst(rst), .start(start && sel), .min_sc(min_sc),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_f(in_f), .in_p(in_p[2:0]), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_idx(b_out_idx), .out_last(b_out_last),
    .out_score(b_out_score), .out_keep(b_out_keep), .busy(b_busy), .done(b_done),
`ifdef CHAIN_BT_STATS_EN
    .stat_chains(b_stat_chains), .stat_kept(b_stat_kept),
`endif
    .overflow(b_overflow)
  );

  // Observation view of whichever instance is selected.
  logic o_ready, o_valid, o_last, o_keep, o_busy, o_done, o_ovf;
  logic [5:0] o_idx;
  logic signed [31:0] o_score;
  always_comb begin
    o_ready = sel ? b_in_ready  : a_in_ready;
    o_valid = sel ? b_out_valid : a_out_valid;
    o_last  = sel ? b_out_last  : a_out_last;
    o_keep  = sel ? b_out_keep  : a_out_keep;
    o_busy  = sel ? b_busy      : a_busy;
    o_done  = sel ? b_done      : a_done;
    o_ovf   = sel ? b_overflow  : a_overflow;
    o_idx   = sel ? {3'b000, b_out_idx} : a_out_idx;
    o_score = sel ? b_out_score : a_out_score;
  end

  typedef struct {
    int     idx;
    bit     last;
    longint score;
    bit     keep;
  } beat_t;

  longint tf [64];
  int     tp [64];
  beat_t  exp_q [$];
  int     exp_chains;
  int     n_err = 0;
  int     n_chk = 0;

  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: walk predecessor links from the highest unvisited qualifying anchor.
  task automatic build_model(input int n, input longint min, input int cap);
    int ne;
    bit vis [64];
    ne = (n > cap) ? cap : n;
    exp_q.delete();
    exp_chains = 0;
    for (int k = 0; k < 64; k++) vis[k] = 1'b0;
    for (int i = ne - 1; i >= 0; i--) begin
      if (!vis[i] && tf[i] >= min) begin
        int j = i;
        exp_chains++;
        forever begin
          beat_t b;
          int q = tp[j];
          longint sc;
          if (q < 0 || q >= j || q >= ne) q = -1;
          sc = tf[i] - ((q >= 0) ? tf[q] : 0);
          if (sc > S_MAX) sc = S_MAX;
          if (sc < S_MIN) sc = S_MIN;
          b.idx = j; b.last = (q < 0) || vis[q]; b.score = sc; b.keep = (sc >= min);
          vis[j] = 1'b1;
          exp_q.push_back(b);
          if (b.last) break;
          j = q;
        end
      end
    end
  endtask

  task automatic feed(input int n, input longint min);
    @(negedge clk);
    min_sc = min[31:0];
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      in_valid = 1'b1;
      in_f     = tf[k][31:0];
      in_p     = tp[k][5:0];
      in_last  = (k == n - 1);
      while (!o_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        check("in_ready_timeout", o_ready, 1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic collect(input int mode, input bit exp_ovf, input int exp_done_cyc);
    int  cyc = 0, done_cyc = -1, total;
    bit  done_seen = 0, stall = 0, r;
    int  s_idx;
    bit  s_last, s_keep;
    longint s_score;
    total = exp_q.size();
    while (!done_seen && cyc < 2000) begin
      if (o_done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end else begin
        if (stall) begin
          check("stall_valid", o_valid, 1);
          check("stall_idx",   o_idx,   s_idx);
          check("stall_last",  o_last,  s_last);
          check("stall_score", o_score, s_score);
          check("stall_keep",  o_keep,  s_keep);
        end
        case (mode)
          0:       r = 1'b1;
          1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: r = 1'($urandom_range(0, 1));
        endcase
        out_ready = r;
        if (o_valid) begin
          if (r) begin
            if (exp_q.size() == 0) begin
              check("beat_count", total + 1, total);
            end else begin
              beat_t e = exp_q.pop_front();
              check("idx",  o_idx,  e.idx);
              check("last", o_last, e.last);
              if (e.last) begin
                check("score", o_score, e.score);
                check("keep",  o_keep,  e.keep);
              end
            end
          end
          stall = !r;
          s_idx = int'(o_idx); s_last = o_last; s_score = longint'(o_score); s_keep = o_keep;
        end else begin
          stall = 0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("done_seen", done_seen, 1);
    check("beats_left", exp_q.size(), 0);
    if (exp_done_cyc >= 0) check("done_latency", done_cyc, exp_done_cyc);
    check("overflow", o_ovf, exp_ovf);
    check("idle_after", o_busy, 0);
`ifdef CHAIN_BT_STATS_EN
    check("stat_chains", sel ? int'(b_stat_chains) : int'(a_stat_chains), exp_chains);
`endif
  endtask

  task automatic run(input int n, input longint min, input int mode, input bit exp_ovf, input int exp_done_cyc);
    build_model(n, min, sel ? CAP_B : CAP_A);
    feed(n, min);
    collect(mode, exp_ovf, exp_done_cyc);
  endtask

  task automatic load_two_chain();
    tf[0] = 10; tf[1] = 20; tf[2] = 30; tf[3] = 15; tf[4] = 40;
    tp[0] = -1; tp[1] = 0;  tp[2] = 1;  tp[3] = -1; tp[4] = 2;
  endtask

  task automatic load_random(input int n);
    for (int k = 0; k < n; k++) begin
      tf[k] = longint'($urandom_range(0, 80)) - 20;
      tp[k] = int'($urandom_range(0, k + 3)) - 2;
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    sel = 1'b0; min_sc = '0; in_f = '0; in_p = '0;
    repeat (3) @(negedge clk);
    check("rst_valid",    o_valid, 0);
    check("rst_busy",     o_busy,  0);
    check("rst_done",     o_done,  0);
    check("rst_in_ready", o_ready, 0);
    check("rst_overflow", o_ovf,   0);
    check("rst_idx",      o_idx,   0);
    check("rst_last",     o_last,  0);
    check("rst_score",    o_score, 0);
    check("rst_keep",     o_keep,  0);
    rst = 1'b1;

    // Two chains, always ready.
    load_two_chain();
    run(5, 5, 0, 0, -1);

    // Chain stops at an already visited anchor.
    tf[0] = 10; tf[1] = 25; tf[2] = 12; tf[3] = 30;
    tp[0] = -1; tp[1] = 0;  tp[2] = 0;  tp[3] = 1;
    run(4, 5, 0, 0, -1);

    // Nothing meets the threshold: done after n scan cycles.
    tf[0] = 1; tf[1] = 2; tf[2] = 3;
    tp[0] = -1; tp[1] = 0; tp[2] = 1;
    run(3, 10, 0, 0, 3);

    // Backpressure on the two-chain case.
    load_two_chain();
    run(5, 5, 1, 0, -1);

    // Saturation at both ends of the score range.
    tf[0] = S_MIN; tf[1] = S_MAX; tf[2] = 10;
    tp[0] = -1;    tp[1] = 0;     tp[2] = 0;
    run(3, 0, 0, 0, -1);
    tf[0] = S_MAX; tf[1] = S_MIN; tf[2] = 10;
    run(3, S_MIN, 2, 0, -1);

    // Overflow and a self-pointing predecessor on the 4-anchor instance.
    sel = 1'b1;
    tf[0] = 5; tf[1] = 6; tf[2] = 7; tf[3] = 8; tf[4] = 9; tf[5] = 9;
    tp[0] = -1; tp[1] = 0; tp[2] = 1; tp[3] = 3; tp[4] = 0; tp[5] = 0;
    run(6, 1, 0, 1, -1);
    sel = 1'b0;

    // Reset while stalled in TRACE.
    load_two_chain();
    build_model(5, 5, CAP_A);
    feed(5, 5);
    out_ready = 1'b0;
    for (int k = 0; k < 50 && !o_valid; k++) @(negedge clk);
    check("pre_rst_valid", o_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_busy",  o_busy,  0);
    check("mid_rst_done",  o_done,  0);
    @(negedge clk);
    rst = 1'b1;
    run(5, 5, 0, 0, -1);

    // Randomized reads with random backpressure.
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(1, 24));
      load_random(n);
      run(n, longint'($urandom_range(0, 40)), 2, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
